// File: rtl/qspi_ahb_splitter.sv
// AHB-Lite 1-to-N address splitter with a default error slave and fault capture.
module qspi_ahb_splitter #(
    parameter int unsigned                  NUM_SLV  = 2,
    parameter int unsigned                  ADDR_W   = 24,
    parameter logic [NUM_SLV*ADDR_W-1:0]    SLV_BASE = {24'h010000, 24'h000000},
    parameter logic [NUM_SLV*ADDR_W-1:0]    SLV_MASK = {24'hFFFF00, 24'h000000},
    parameter logic [NUM_SLV-1:0]           RO_MASK  = 2'b01
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic [31:0]             HRDATA,
    output logic                    HRESP,
    output logic [NUM_SLV-1:0]      S_HSEL,
    input  logic [NUM_SLV-1:0]      S_HREADYOUT,
    input  logic [32*NUM_SLV-1:0]   S_HRDATA,
    input  logic [NUM_SLV-1:0]      S_HRESP,
    output logic [31:0]             err_addr,
    output logic [7:0]              err_count,
    output logic                    irq_err
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_SLV-1:0]   hit_oh;
    logic                 any_hit;
    logic                 valid_c;
    logic                 fault_c;
    logic [NUM_SLV-1:0]   dsel;
    logic                 derr;
    logic                 unused_bits;

    // Only the low ADDR_W address bits and HTRANS[1] take part in decode.
    assign unused_bits = ^{HTRANS[0], HADDR};

    // Base/mask decode with lowest-index priority, giving a one-hot hit vector.
    always_comb begin
        hit_oh  = '0;
        any_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (!any_hit &&
                ((HADDR[ADDR_W-1:0] & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                hit_oh[i] = 1'b1;
                any_hit   = 1'b1;
            end
        end
    end

    assign valid_c = HSEL & HTRANS[1] & HREADY;
    assign fault_c = valid_c & (~any_hit | (HWRITE & (|(hit_oh & RO_MASK))));

    // Faulting transfers are steered to the default slave and never reach a real one.
    assign S_HSEL = {NUM_SLV{HSEL & ~fault_c}} & hit_oh;

    // Data-phase select follows the accepted address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= '0;
            derr <= 1'b0;
        end else if (HREADY) begin
            dsel <= (valid_c && !fault_c) ? hit_oh : '0;
            derr <= fault_c;
        end
    end

    // Error FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Error FSM next state: two-cycle ERROR, back-to-back faults chain ERR2 -> ERR1.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fault_c) state_nxt = ST_ERR1;
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = fault_c ? ST_ERR1 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Data-phase response mux: default error slave, selected slave, or idle OKAY.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        if (derr) begin
            HREADYOUT = (state != ST_ERR1);
            HRESP     = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_SLV; i++) begin
                if (dsel[i]) begin
                    HREADYOUT = S_HREADYOUT[i];
                    HRESP     = S_HRESP[i];
                    HRDATA    = S_HRDATA[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Fault capture for software: address, saturating count, one-cycle interrupt.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_addr  <= '0;
            err_count <= '0;
            irq_err   <= 1'b0;
        end else begin
            irq_err <= fault_c;
            if (fault_c) begin
                err_addr <= HADDR;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_ahb_splitter.sv
// Directed table-driven bench for qspi_ahb_splitter (three-slave configuration).
module tb_qspi_ahb_splitter;

    localparam int unsigned NS = 3;
    localparam logic [1:0]  NSQ = 2'b10;
    localparam logic [1:0]  IDL = 2'b00;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hsel = 1'b0;
    logic [31:0]       haddr = '0;
    logic [1:0]        htrans = 2'b00;
    logic              hwrite = 1'b0;
    logic              hready;
    logic              hreadyout;
    logic [31:0]       hrdata;
    logic              hresp;
    logic [NS-1:0]     s_hsel;
    logic [NS-1:0]     s_hreadyout = '1;
    logic [32*NS-1:0]  s_hrdata;
    logic [NS-1:0]     s_hresp;
    logic [31:0]       err_addr;
    logic [7:0]        err_count;
    logic              irq_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Single-master system: the bus ready is the splitter's own ready.
    assign hready   = hreadyout;
    assign s_hrdata = {32'hC2C22222, 32'hB1B11111, 32'hA0A00000};
    assign s_hresp  = '0;

    always #5 clk = ~clk;

    qspi_ahb_splitter #(
        .NUM_SLV  (NS),
        .ADDR_W   (24),
        .SLV_BASE ({24'h020000, 24'h010000, 24'h000000}),
        .SLV_MASK ({24'hFF0000, 24'hFFFF00, 24'hFF0000}),
        .RO_MASK  (3'b001)
    ) dut (
        .HCLK        (clk),
        .HRESETn     (rst_n),
        .HSEL        (hsel),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .HWRITE      (hwrite),
        .HREADY      (hready),
        .HREADYOUT   (hreadyout),
        .HRDATA      (hrdata),
        .HRESP       (hresp),
        .S_HSEL      (s_hsel),
        .S_HREADYOUT (s_hreadyout),
        .S_HRDATA    (s_hrdata),
        .S_HRESP     (s_hresp),
        .err_addr    (err_addr),
        .err_count   (err_count),
        .irq_err     (irq_err)
    );

    typedef struct {
        logic        hsel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  srdy;
        logic [2:0]  e_sel;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        logic [7:0]  e_cnt;
        logic        e_irq;
        logic [31:0] e_eaddr;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic hs, input logic [31:0] a, input logic [1:0] t,
                                input logic w, input logic [2:0] r, input logic [2:0] es,
                                input logic erd, input logic ers, input logic [31:0] ed,
                                input logic [7:0] ec, input logic ei, input logic [31:0] ea);
        vec_t v;
        v.hsel = hs; v.addr = a; v.trans = t; v.wr = w; v.srdy = r;
        v.e_sel = es; v.e_rdy = erd; v.e_resp = ers; v.e_data = ed;
        v.e_cnt = ec; v.e_irq = ei; v.e_eaddr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Back-to-back reads, slave1 with two wait states
        vecs[0]  = mk(1, 32'h000100, NSQ, 0, 3'b111, 3'b001, 1, 0, 32'h0,        0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h010004, NSQ, 0, 3'b111, 3'b010, 1, 0, 32'hA0A00000, 0, 0, 32'h0);
        vecs[2]  = mk(0, 32'h0,      IDL, 0, 3'b101, 3'b000, 0, 0, 32'hB1B11111, 0, 0, 32'h0);
        vecs[3]  = mk(0, 32'h0,      IDL, 0, 3'b101, 3'b000, 0, 0, 32'hB1B11111, 0, 0, 32'h0);
        vecs[4]  = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 0, 32'hB1B11111, 0, 0, 32'h0);
        vecs[5]  = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 0, 32'h0,        0, 0, 32'h0);
        // Write to read-only slave0
        vecs[6]  = mk(1, 32'h000040, NSQ, 1, 3'b111, 3'b000, 1, 0, 32'h0, 0, 0, 32'h0);
        vecs[7]  = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 0, 1, 32'h0, 1, 1, 32'h40);
        vecs[8]  = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 1, 32'h0, 1, 0, 32'h40);
        vecs[9]  = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 0, 32'h0, 1, 0, 32'h40);
        // Unmapped read, then slave2 read issued during ERR2
        vecs[10] = mk(1, 32'h030000, NSQ, 0, 3'b111, 3'b000, 1, 0, 32'h0,        1, 0, 32'h40);
        vecs[11] = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 0, 1, 32'h0,        2, 1, 32'h30000);
        vecs[12] = mk(1, 32'h020010, NSQ, 0, 3'b111, 3'b100, 1, 1, 32'h0,        2, 0, 32'h30000);
        vecs[13] = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 0, 32'hC2C22222, 2, 0, 32'h30000);
        // Two faults, second presented in ERR2
        vecs[14] = mk(1, 32'h000000, NSQ, 1, 3'b111, 3'b000, 1, 0, 32'h0, 2, 0, 32'h30000);
        vecs[15] = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 0, 1, 32'h0, 3, 1, 32'h0);
        vecs[16] = mk(1, 32'h030000, NSQ, 0, 3'b111, 3'b000, 1, 1, 32'h0, 3, 0, 32'h0);
        vecs[17] = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 0, 1, 32'h0, 4, 1, 32'h30000);
        vecs[18] = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 1, 32'h0, 4, 0, 32'h30000);
        vecs[19] = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 0, 32'h0, 4, 0, 32'h30000);
        // IDLE and BUSY with HSEL high: nothing happens
        vecs[20] = mk(1, 32'h030000, 2'b00, 0, 3'b111, 3'b000, 1, 0, 32'h0, 4, 0, 32'h30000);
        vecs[21] = mk(1, 32'h030000, 2'b01, 0, 3'b111, 3'b000, 1, 0, 32'h0, 4, 0, 32'h30000);
        vecs[22] = mk(0, 32'h0,      IDL, 0, 3'b111, 3'b000, 1, 0, 32'h0, 4, 0, 32'h30000);

        // Reset values
        #12;
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp",     32'(hresp),     32'd0);
        check("rst_hrdata",    hrdata,         32'd0);
        check("rst_s_hsel",    32'(s_hsel),    32'd0);
        check("rst_err_addr",  err_addr,       32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_irq_err",   32'(irq_err),   32'd0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            hsel        = vecs[i].hsel;
            haddr       = vecs[i].addr;
            htrans      = vecs[i].trans;
            hwrite      = vecs[i].wr;
            s_hreadyout = vecs[i].srdy;
            @(negedge clk);
            check($sformatf("v%0d_s_hsel", i),    32'(s_hsel),    32'(vecs[i].e_sel));
            check($sformatf("v%0d_hreadyout", i), 32'(hreadyout), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d_hresp", i),     32'(hresp),     32'(vecs[i].e_resp));
            check($sformatf("v%0d_hrdata", i),    hrdata,         vecs[i].e_data);
            check($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_irq_err", i),   32'(irq_err),   32'(vecs[i].e_irq));
            check($sformatf("v%0d_err_addr", i),  err_addr,       vecs[i].e_eaddr);
        end

        // Continuous unmapped reads: well over 255 faults, counter saturates
        @(posedge clk);
        #1;
        hsel   = 1'b1;
        haddr  = 32'h030000;
        htrans = NSQ;
        hwrite = 1'b0;
        repeat (700) @(posedge clk);
        @(negedge clk);
        check("sat_err_count", 32'(err_count), 32'd255);

        // Find an ERR1 cycle, then reset asynchronously inside it
        begin
            bit found = 1'b0;
            for (int k = 0; k < 4 && !found; k++) begin
                if (hreadyout === 1'b0) found = 1'b1;
                else @(negedge clk);
            end
            check("err1_found", 32'(found), 32'd1);
        end
        check("err1_hresp",   32'(hresp),   32'd1);
        check("err1_irq_err", 32'(irq_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hreadyout", 32'(hreadyout), 32'd1);
        check("arst_hresp",     32'(hresp),     32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        check("arst_irq_err",   32'(irq_err),   32'd0);
        check("arst_err_addr",  err_addr,       32'd0);

        // Recovery after reset: a slave0 read is forwarded and completes
        hsel = 1'b0;
        htrans = IDL;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        hsel   = 1'b1;
        haddr  = 32'h000100;
        htrans = NSQ;
        @(negedge clk);
        check("post_s_hsel", 32'(s_hsel), 32'b001);
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        htrans = IDL;
        @(negedge clk);
        check("post_hrdata", hrdata, 32'hA0A00000);
        check("post_hresp",  32'(hresp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
